// File: rtl/entropy_hazard_ctrl_if.sv
// Bus bundle for entropy_hazard_ctrl: entropy/threshold/control inputs, FSM
// status outputs and the transition-log read port.
interface entropy_hazard_ctrl_if #(
   parameter int NUM_CH = 4,
   parameter int EW     = 16
);
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH*EW-1:0] entropy_in;
   logic [NUM_CH-1:0]    ch_valid;
   logic [EW-1:0]        stall_thresh;
   logic [EW-1:0]        flush_thresh;
   logic [1:0]           ml_action;
   logic [2:0]           instr_type;
   logic                 flush_override;
   logic                 lock_override;
   logic                 lock_clear;
   logic                 log_rd_en;

   logic [1:0]           fsm_state;
   logic                 stall_out;
   logic                 flush_out;
   logic                 lock_out;
   logic [CHW-1:0]       max_ch;
   logic [EW+4:0]        log_data;
   logic                 log_valid;
   logic                 log_overflow;

   modport master (
      output entropy_in, ch_valid, stall_thresh, flush_thresh, ml_action,
             instr_type, flush_override, lock_override, lock_clear, log_rd_en,
      input  fsm_state, stall_out, flush_out, lock_out, max_ch,
             log_data, log_valid, log_overflow
   );

   modport slave (
      input  entropy_in, ch_valid, stall_thresh, flush_thresh, ml_action,
             instr_type, flush_override, lock_override, lock_clear, log_rd_en,
      output fsm_state, stall_out, flush_out, lock_out, max_ch,
             log_data, log_valid, log_overflow
   );
endinterface

// File: rtl/entropy_hazard_ctrl.sv
// Entropy-driven hazard controller: 2-stage NORMAL/STALL/FLUSH/LOCK FSM with
// an optional show-ahead transition log, built only when ENTROPY_LOG_EN is defined.
module entropy_hazard_ctrl #(
   parameter int NUM_CH      = 4,
   parameter int EW          = 16,
   parameter int HOLD_CYCLES = 4,
   parameter int LOG_DEPTH   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   entropy_hazard_ctrl_if.slave bus
);
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [7:0] HOLD_LIM = 8'(HOLD_CYCLES);

   typedef enum logic [1:0] {
      NORMAL = 2'b00,
      STALL  = 2'b01,
      FLUSH  = 2'b10,
      LOCK   = 2'b11
   } state_t;

   logic [EW-1:0]  max_d, max_q, stall_th_q, flush_th_q;
   logic [CHW-1:0] max_idx_d, max_ch_q;
   logic           found;
   logic [1:0]     ml_q;
   logic [2:0]     instr_q;
   logic           flush_ov_q, lock_ov_q, clr_q;

   // Strict '>' keeps the lowest index on ties.
   always_comb begin
      max_d     = '0;
      max_idx_d = '0;
      found     = 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (bus.ch_valid[c] && (!found || bus.entropy_in[c*EW +: EW] > max_d)) begin
            max_d     = bus.entropy_in[c*EW +: EW];
            max_idx_d = CHW'(c);
            found     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_q      <= '0;
         max_ch_q   <= '0;
         stall_th_q <= '0;
         flush_th_q <= '0;
         ml_q       <= '0;
         instr_q    <= '0;
         flush_ov_q <= 1'b0;
         lock_ov_q  <= 1'b0;
         clr_q      <= 1'b0;
      end else begin
         max_q      <= max_d;
         max_ch_q   <= max_idx_d;
         stall_th_q <= bus.stall_thresh;
         flush_th_q <= bus.flush_thresh;
         ml_q       <= bus.ml_action;
         instr_q    <= bus.instr_type;
         flush_ov_q <= bus.flush_override;
         lock_ov_q  <= bus.lock_override;
         clr_q      <= bus.lock_clear;
      end
   end

   logic lock_c, flush_c, stall_c;
   assign lock_c  = lock_ov_q || (ml_q == 2'b11);
   assign flush_c = flush_ov_q || (max_q >= flush_th_q) || (ml_q == 2'b10);
   assign stall_c = (max_q >= stall_th_q) || (ml_q == 2'b01);

   state_t     state, state_nxt;
   logic [7:0] hold_cnt, cnt_nxt, cnt_inc;
   logic       stall_q, flush_q, lock_q;

   // FLUSH always falls through STALL, which is what makes back-to-back flush
   // conditions alternate FLUSH/STALL and forces hysteresis after every flush.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      cnt_inc   = hold_cnt + 8'd1;
      unique case (state)
         NORMAL: begin
            if (lock_c)       state_nxt = LOCK;
            else if (flush_c) state_nxt = FLUSH;
            else if (stall_c) state_nxt = STALL;
         end
         STALL: begin
            if (lock_c)                 state_nxt = LOCK;
            else if (flush_c)           state_nxt = FLUSH;
            else if (stall_c)           cnt_nxt   = '0;
            else if (cnt_inc == HOLD_LIM) state_nxt = NORMAL;
            else                        cnt_nxt   = cnt_inc;
         end
         FLUSH: begin
            state_nxt = lock_c ? LOCK : STALL;
         end
         LOCK: begin
            if (!lock_c && clr_q) state_nxt = NORMAL;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= NORMAL;
         hold_cnt <= '0;
         stall_q  <= 1'b0;
         flush_q  <= 1'b0;
         lock_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= cnt_nxt;
         stall_q  <= (state_nxt == STALL) || (state_nxt == LOCK);
         flush_q  <= (state_nxt == FLUSH);
         lock_q   <= (state_nxt == LOCK);
      end
   end

   assign bus.fsm_state = state;
   assign bus.stall_out = stall_q;
   assign bus.flush_out = flush_q;
   assign bus.lock_out  = lock_q;
   assign bus.max_ch    = max_ch_q;

`ifdef ENTROPY_LOG_EN
   localparam int AW = $clog2(LOG_DEPTH);

   logic [EW+4:0] mem [LOG_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          ovf_q, push, full, empty, do_pop, do_push;

   assign push    = (state_nxt != state);
   assign full    = (count == (AW+1)'(LOG_DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = bus.log_rd_en && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
         if (push && !do_push) ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= {state_nxt, max_q, instr_q};
   end

   assign bus.log_data     = empty ? '0 : mem[rd_ptr];
   assign bus.log_valid    = !empty;
   assign bus.log_overflow = ovf_q;
`else
   logic unused_log;
   assign unused_log       = &{1'b0, bus.log_rd_en, instr_q};
   assign bus.log_data     = '0;
   assign bus.log_valid    = 1'b0;
   assign bus.log_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_entropy_hazard_ctrl.sv
// Directed self-checking bench for entropy_hazard_ctrl; log checks adapt to
// whether ENTROPY_LOG_EN is defined.
module tb_entropy_hazard_ctrl;
   localparam logic [1:0] S_N = 2'b00, S_S = 2'b01, S_F = 2'b10, S_L = 2'b11;
`ifdef ENTROPY_LOG_EN
   localparam bit LOG_EN = 1'b1;
`else
   localparam bit LOG_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   entropy_hazard_ctrl_if #(.NUM_CH(4), .EW(16)) bus ();

   entropy_hazard_ctrl #(
      .NUM_CH(4), .EW(16), .HOLD_CYCLES(4), .LOG_DEPTH(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_fsm(input string tag, input logic [1:0] st);
      chk({tag, ".state"}, 32'(bus.fsm_state), 32'(st));
      chk({tag, ".stall"}, 32'(bus.stall_out), 32'((st == S_S) || (st == S_L)));
      chk({tag, ".flush"}, 32'(bus.flush_out), 32'(st == S_F));
      chk({tag, ".lock"},  32'(bus.lock_out),  32'(st == S_L));
   endtask

   function automatic logic [20:0] ent(input logic [1:0] s, input logic [15:0] m,
                                       input logic [2:0] t);
      return {s, m, t};
   endfunction

   function automatic logic [63:0] pack4(input logic [15:0] c0, input logic [15:0] c1,
                                         input logic [15:0] c2, input logic [15:0] c3);
      return {c3, c2, c1, c0};
   endfunction

   // Checks the head entry and pops it; without the log, the port must stay idle.
   task automatic pop_chk(input string tag, input logic [20:0] exp);
      chk({tag, ".valid"}, 32'(bus.log_valid), 32'(LOG_EN));
      chk({tag, ".data"},  32'(bus.log_data),  LOG_EN ? 32'(exp) : 32'd0);
      bus.log_rd_en = 1'b1;
      tick();
      bus.log_rd_en = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 16; i++) begin
         if (bus.log_valid) begin
            bus.log_rd_en = 1'b1;
            tick();
            bus.log_rd_en = 1'b0;
         end
      end
   endtask

   task automatic idle_inputs();
      bus.entropy_in     = '0;
      bus.ch_valid       = '0;
      bus.stall_thresh   = 16'd100;
      bus.flush_thresh   = 16'd50000;
      bus.ml_action      = 2'b00;
      bus.instr_type     = 3'd0;
      bus.flush_override = 1'b0;
      bus.lock_override  = 1'b0;
      bus.lock_clear     = 1'b0;
      bus.log_rd_en      = 1'b0;
   endtask

   initial begin
      idle_inputs();
      #2 rst = 1'b1;
      tick();
      tick();
      chk_fsm("rst", S_N);
      chk("rst.max_ch", 32'(bus.max_ch), 0);
      chk("rst.log_valid", 32'(bus.log_valid), 0);
      chk("rst.log_data", 32'(bus.log_data), 0);
      chk("rst.log_ovf", 32'(bus.log_overflow), 0);

      // Zeroed stage-1 thresholds make 0>=0 a flush on the first edge after reset.
      rst = 1'b0;
      repeat (8) tick();
      chk_fsm("settle", S_N);
      pop_chk("settle.log0", ent(S_F, 16'd0, 3'd0));
      pop_chk("settle.log1", ent(S_S, 16'd0, 3'd0));
      pop_chk("settle.log2", ent(S_N, 16'd0, 3'd0));

      // ch2=150 for one cycle: STALL two edges later, NORMAL after 4 quiet cycles.
      bus.entropy_in = pack4(16'd0, 16'd0, 16'd150, 16'd0);
      bus.ch_valid   = 4'b0100;
      bus.instr_type = 3'd5;
      tick();
      chk("stall.max_ch", 32'(bus.max_ch), 2);
      chk_fsm("stall.e1", S_N);
      bus.ch_valid = 4'b0000;
      tick();
      chk_fsm("stall.enter", S_S);
      repeat (3) begin
         tick();
         chk_fsm("stall.hold", S_S);
      end
      tick();
      chk_fsm("stall.exit", S_N);
      pop_chk("stall.log0", ent(S_S, 16'd150, 3'd5));
      pop_chk("stall.log1", ent(S_N, 16'd0, 3'd5));

      // A stall condition mid-hysteresis restarts the quiet count.
      bus.ml_action = 2'b01;
      tick();
      bus.ml_action = 2'b00;
      tick();
      chk_fsm("restart.enter", S_S);
      bus.ml_action = 2'b01;
      tick();
      bus.ml_action = 2'b00;
      tick();
      tick();
      tick();
      chk_fsm("restart.e6", S_S);
      tick();
      chk_fsm("restart.e7", S_S);
      tick();
      chk_fsm("restart.exit", S_N);
      drain();

      // Tie between ch1 and ch3 above flush_thresh; larger ch0 is not valid.
      bus.instr_type = 3'd3;
      bus.entropy_in = pack4(16'd65535, 16'd60000, 16'd7, 16'd60000);
      bus.ch_valid   = 4'b1010;
      tick();
      chk("flush.max_ch", 32'(bus.max_ch), 1);
      bus.ch_valid = 4'b0000;
      tick();
      chk_fsm("flush.enter", S_F);
      tick();
      chk_fsm("flush.to_stall", S_S);
      repeat (3) tick();
      chk_fsm("flush.hold", S_S);
      tick();
      chk_fsm("flush.exit", S_N);
      pop_chk("flush.log0", ent(S_F, 16'd60000, 3'd3));
      pop_chk("flush.log1", ent(S_S, 16'd0, 3'd3));
      pop_chk("flush.log2", ent(S_N, 16'd0, 3'd3));

      // Persistent flush request alternates FLUSH and STALL.
      bus.flush_override = 1'b1;
      tick();
      tick();
      chk_fsm("alt.e2", S_F);
      tick();
      chk_fsm("alt.e3", S_S);
      tick();
      chk_fsm("alt.e4", S_F);
      bus.flush_override = 1'b0;
      tick();
      chk_fsm("alt.e5", S_S);
      repeat (4) tick();
      chk_fsm("alt.exit", S_N);
      drain();

      // Lock pulse is sticky until lock_clear.
      bus.lock_override = 1'b1;
      tick();
      bus.lock_override = 1'b0;
      tick();
      chk_fsm("lock.enter", S_L);
      repeat (20) tick();
      chk_fsm("lock.held20", S_L);
      bus.lock_clear = 1'b1;
      tick();
      bus.lock_clear = 1'b0;
      chk_fsm("lock.clr_pipe", S_L);
      tick();
      chk_fsm("lock.exit", S_N);

      // lock_clear cannot release while a lock condition is still present.
      bus.ml_action  = 2'b11;
      bus.lock_clear = 1'b1;
      tick();
      tick();
      chk_fsm("lockml.enter", S_L);
      tick();
      chk_fsm("lockml.blocked", S_L);
      bus.ml_action = 2'b00;
      tick();
      chk_fsm("lockml.pipe", S_L);
      tick();
      chk_fsm("lockml.exit", S_N);
      bus.lock_clear = 1'b0;
      drain();

      // Lock beats flush when both arrive together.
      bus.lock_override  = 1'b1;
      bus.flush_override = 1'b1;
      tick();
      bus.lock_override  = 1'b0;
      bus.flush_override = 1'b0;
      tick();
      chk_fsm("both.enter", S_L);
      tick();
      chk_fsm("both.held", S_L);
      bus.lock_clear = 1'b1;
      tick();
      tick();
      chk_fsm("both.exit", S_N);
      bus.lock_clear = 1'b0;
      drain();

      // One transition per cycle via ml_action toggling with lock_clear held.
      bus.instr_type = 3'd6;
      bus.lock_clear = 1'b1;
      for (int i = 0; i < 9; i++) begin
         bus.ml_action = (i % 2 == 0) ? 2'b11 : 2'b00;
         tick();
      end
      chk("ovf.at8", 32'(bus.log_overflow), 0);
      chk("ovf.valid8", 32'(bus.log_valid), 32'(LOG_EN));
      bus.ml_action = 2'b00;
      tick();
      chk("ovf.at9", 32'(bus.log_overflow), 32'(LOG_EN));
      chk_fsm("ovf.e10", S_L);
      tick();
      chk_fsm("ovf.e11", S_N);
      bus.ml_action = 2'b11;
      tick();
      bus.ml_action  = 2'b00;
      bus.lock_clear = 1'b0;
      bus.log_rd_en  = 1'b1;
      tick();
      bus.log_rd_en = 1'b0;
      chk_fsm("ovf.pushpop", S_L);
      chk("ovf.sticky", 32'(bus.log_overflow), 32'(LOG_EN));
      for (int i = 0; i < 8; i++) begin
         pop_chk($sformatf("ovf.pop%0d", i), ent((i % 2 == 0) ? S_N : S_L, 16'd0, 3'd6));
      end
      chk("ovf.empty", 32'(bus.log_valid), 0);
      chk("ovf.after_pops", 32'(bus.log_overflow), 32'(LOG_EN));
      bus.lock_clear = 1'b1;
      tick();
      tick();
      bus.lock_clear = 1'b0;
      chk_fsm("ovf.unlock", S_N);
      drain();

      // Reset during STALL with the hysteresis counter at 2.
      bus.instr_type = 3'd1;
      bus.entropy_in = pack4(16'd0, 16'd50, 16'd150, 16'd0);
      bus.ch_valid   = 4'b0110;
      tick();
      bus.ch_valid = 4'b0010;
      tick();
      tick();
      tick();
      chk_fsm("rststall.pre", S_S);
      chk("rststall.pre_max_ch", 32'(bus.max_ch), 1);
      #1 rst = 1'b1;
      #1;
      chk_fsm("rststall.post", S_N);
      chk("rststall.max_ch", 32'(bus.max_ch), 0);
      chk("rststall.log_valid", 32'(bus.log_valid), 0);
      chk("rststall.log_ovf", 32'(bus.log_overflow), 0);
      tick();
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/entropy_hazard_ctrl.md
ENTROPY_HAZARD_CTRL -- requirements
Module: entropy_hazard_ctrl

Interface
REQ-001 Parameter NUM_CH, 4, number of entropy channels (1..16).
REQ-002 Parameter EW, 16, entropy width per channel, in bits.
REQ-003 Parameter HOLD_CYCLES, 4, STALL exit hysteresis in cycles (1..255).
REQ-004 Parameter LOG_DEPTH, 8, transition-log FIFO depth (power of two, >=2).
REQ-005 clk  in  1  single clock, rising-edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 entropy_in  in  NUM_CH*EW  channel c at bits [c*EW +: EW].
REQ-008 ch_valid  in  NUM_CH  per-channel qualifier.
REQ-009 stall_thresh  in  EW  stall threshold, unsigned.
REQ-010 flush_thresh  in  EW  flush threshold, unsigned.
REQ-011 ml_action  in  2  00 normal, 01 stall, 10 flush, 11 lock.
REQ-012 instr_type  in  3  instruction class, logged on transition.
REQ-013 flush_override  in  1  analog flush request.
REQ-014 lock_override  in  1  quantum/analog lock request.
REQ-015 lock_clear  in  1  releases LOCK.
REQ-016 log_rd_en  in  1  pops the log head.
REQ-017 fsm_state  out  2  00 NORMAL, 01 STALL, 10 FLUSH, 11 LOCK.
REQ-018 stall_out  out  1  high in STALL or LOCK.
REQ-019 flush_out  out  1  high in FLUSH.
REQ-020 lock_out  out  1  high in LOCK.
REQ-021 max_ch  out  max(1,$clog2(NUM_CH))  index of the current max-entropy channel.
REQ-022 log_data  out  EW+5  {new_state[1:0], max_entropy[EW-1:0], instr_type[2:0]} at the FIFO head.
REQ-023 log_valid  out  1  FIFO non-empty.
REQ-024 log_overflow  out  1  sticky; a log push was dropped.

Function
REQ-025 Stage 1 SHALL register all inputs, plus max_q/max_ch = the largest valid channel entropy (ties go to the lowest index; no valid channel gives 0/0).
REQ-026 Stage 2 SHALL update fsm_state from the stage-1 values, giving 2 cycles from input to output; stall_out, flush_out and lock_out SHALL be decoded from the registered state.
REQ-027 Next-state priority: (1) lock_override or ml_action=11 -> LOCK; (2) flush_override, max_q>=flush_thresh, or ml_action=10 -> FLUSH; (3) max_q>=stall_thresh or ml_action=01 -> STALL; (4) otherwise NORMAL.
REQ-028 LOCK SHALL be sticky, exiting to NORMAL only in a cycle where lock_clear=1 and no lock condition holds; lock_clear has no effect in any other state.
REQ-029 FLUSH SHALL last exactly 1 cycle and then re-evaluate REQ-027; consecutive flush conditions re-enter FLUSH on alternating cycles via STALL (FLUSH->STALL->FLUSH).
REQ-030 STALL exit: a counter SHALL count consecutive cycles in which conditions (1)-(3) are all absent; the state moves to NORMAL when the count reaches HOLD_CYCLES; any stall condition resets the counter to 0; FLUSH/LOCK conditions preempt immediately.
REQ-031 From FLUSH, condition (4) SHALL enter STALL with the counter at 0 (hysteresis is always applied after a flush).
REQ-032 Each cycle in which fsm_state changes SHALL push one log entry holding the new state, max_q and the stage-1 instr_type.
REQ-033 Log FIFO is show-ahead: log_data is valid whenever log_valid=1; log_rd_en with an empty FIFO is ignored.
REQ-034 Push while full without a pop: the entry SHALL be dropped and log_overflow set; simultaneous push and pop while full SHALL succeed; log_overflow clears only on reset.
REQ-035 Comparisons are unsigned and full-width; there is no saturation or wrap anywhere except the FIFO pointers (modulo LOG_DEPTH).

Reset
REQ-036 On rst asserted, asynchronously: fsm_state=NORMAL, all stage-1 registers, hysteresis counter and max_ch =0, FIFO empty, log_valid=0, log_overflow=0, log_data=0.
REQ-037 Reset asserted mid-STALL or mid-LOCK SHALL abort immediately; no log entry is written for the reset.

Configuration
REQ-038 With ENTROPY_LOG_EN defined, the log FIFO (REQ-032..034) is built; without it, no FIFO storage exists, log_data/log_valid/log_overflow are tied to 0, log_rd_en is ignored, and the FSM behaviour is unchanged.

Verification
REQ-039 NUM_CH=4, stall_thresh=100, ch2=150 valid for 1 cycle -> STALL 2 cycles later, max_ch=2; NORMAL after exactly HOLD_CYCLES=4 quiet cycles.
REQ-040 ch1=ch3=60000, flush_thresh=50000 -> max_ch=1, single-cycle FLUSH, then STALL; log holds entries {10,60000,type} and {01,...}.
REQ-041 lock_override pulsed 1 cycle -> LOCK held with lock_clear=0 for 20 cycles; lock_clear=1 -> NORMAL next cycle.
REQ-042 lock_override and flush_override raised together -> LOCK; flush_out stays 0.
REQ-043 LOG_DEPTH=8, 9 transitions without reads -> log_overflow=1 and 8 entries retained; push+pop while full -> count stays 8, overflow unchanged.
REQ-044 rst asserted during STALL with counter=2 -> outputs at reset values immediately; with ENTROPY_LOG_EN undefined, log_valid stays 0 throughout.
